// File: rtl/seq_alu_exec_if.sv
// ----------------------------------------------------------------------------
// seq_alu_exec_if
//   Request/response bundle of the sequential ALU execute unit.
//
//   Request  : In_Valid / In_Ready handshake carrying ALU_Sel, Op_A, Op_B.
//   Response : Out_Valid / Out_Ready handshake carrying Result and the
//              Zero / Carry / Overflow / Sign flags.
//
//   master : the pipeline side. It issues requests and consumes results.
//   slave  : the execute unit (seq_alu_exec).
// ----------------------------------------------------------------------------
interface seq_alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             In_Valid;
  logic             In_Ready;
  logic [3:0]       ALU_Sel;
  logic [WIDTH-1:0] Op_A;
  logic [WIDTH-1:0] Op_B;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Carry;
  logic             Overflow;
  logic             Sign;

  modport master (
    output In_Valid, ALU_Sel, Op_A, Op_B, Out_Ready,
    input  In_Ready, Out_Valid, Result, Zero, Carry, Overflow, Sign
  );

  modport slave (
    input  In_Valid, ALU_Sel, Op_A, Op_B, Out_Ready,
    output In_Ready, Out_Valid, Result, Zero, Carry, Overflow, Sign
  );
endinterface

// File: rtl/seq_alu_exec.sv
// ----------------------------------------------------------------------------
// seq_alu_exec
//   Execute-stage ALU with a valid/ready request and a valid/ready response.
//   ADD/SUB/PASS/OR/AND/XOR/SLT/SLTU complete in one cycle. SRL/SLL/SRA run
//   one bit per cycle, so a shift by n holds the unit for n extra cycles.
//   Undefined opcodes behave as PASS (Result = Op_B).
//
//   Build option: define BARREL_SHIFT_EN to compute shifts combinationally
//   in one cycle. The SHIFT state and the shift counter then disappear;
//   results and flags are identical, only Out_Valid timing changes.
//
// Ports
//   Clk   : clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : seq_alu_exec_if.slave
//           In_Valid/In_Ready, ALU_Sel, Op_A, Op_B     (request)
//           Out_Valid/Out_Ready, Result, Zero, Carry,
//           Overflow, Sign                             (response)
// ----------------------------------------------------------------------------
module seq_alu_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          Clk,
  input  logic          Rst_n,
  seq_alu_exec_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
  } alu_out_t;

  // Single-cycle evaluation. PASS is the default arm, so undefined codes
  // fall through to Result = Op_B. SUB is A + ~B + 1, which makes the
  // adder carry-out read as "no borrow".
  function automatic alu_out_t alu_eval(input logic [3:0]       op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    alu_out_t         o;
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    o     = '0;
    sub   = (op == OP_SUB);
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    case (op)
      OP_ADD, OP_SUB: begin
        o.result = sum[WIDTH-1:0];
        o.carry  = sum[WIDTH];
        o.ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:   o.result = a | b;
      OP_AND:  o.result = a & b;
      OP_XOR:  o.result = a ^ b;
      OP_SLT:  o.result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: o.result = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef BARREL_SHIFT_EN
      OP_SRL:  o.result = a >> b[SHAMT_W-1:0];
      OP_SLL:  o.result = a << b[SHAMT_W-1:0];
      OP_SRA:  o.result = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
`else
      // Only shamt == 0 reaches this arm; nonzero amounts go iterative.
      OP_SRL, OP_SLL, OP_SRA: o.result = a;
`endif
      default: o.result = b;
    endcase
    return o;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic             r_sign;

  alu_out_t         w_alu;
  alu_out_t         w_load_val;
  logic             w_load;
  logic             w_start_shift;
  logic             w_go_shift;
  logic             w_in_ready;
  logic             w_out_valid;

  assign w_alu = alu_eval(bus.ALU_Sel, bus.Op_A, bus.Op_B);

`ifndef BARREL_SHIFT_EN
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   w_work_next;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt    = bus.Op_B[SHAMT_W-1:0];
  assign w_go_shift = ((bus.ALU_Sel == OP_SRL) || (bus.ALU_Sel == OP_SLL) ||
                       (bus.ALU_Sel == OP_SRA)) && (w_shamt != '0);

  // One-bit step of the working register; SRA replicates the sign bit.
  always_comb begin
    case (r_op)
      OP_SLL:  w_work_next = {r_work[WIDTH-2:0], 1'b0};
      OP_SRA:  w_work_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_work_next = {1'b0, r_work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_op   <= '0;
      r_work <= '0;
      r_cnt  <= '0;
    end else if (w_start_shift) begin
      // The op is latched here so later bus changes cannot disturb it.
      r_op   <= bus.ALU_Sel;
      r_work <= bus.Op_A;
      r_cnt  <= w_shamt;
    end else if (r_state == S_SHIFT) begin
      r_work <= w_work_next;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end
`else
  assign w_go_shift = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: every clocked register uses <= so all flops update from the
      // same pre-edge values, regardless of statement order.
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    w_next_state  = r_state;
    w_load        = 1'b0;
    w_load_val    = w_alu;
    w_start_shift = 1'b0;
    w_in_ready    = 1'b0;
    w_out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.In_Valid) begin
          if (w_go_shift) begin
            w_start_shift = 1'b1;
            w_next_state  = S_SHIFT;
          end else begin
            w_load       = 1'b1;
            w_next_state = S_DONE;
          end
        end
      end
`ifndef BARREL_SHIFT_EN
      S_SHIFT: begin
        // Last step: capture the shifted value as it goes 1 -> 0.
        if (r_cnt == SHAMT_W'(1)) begin
          w_load       = 1'b1;
          w_load_val   = {w_work_next, 1'b0, 1'b0};
          w_next_state = S_DONE;
        end
      end
`endif
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.Out_Ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output registers; held through DONE until the consumer takes them.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      // NOTE: the result and flags are reset (not just the state) so an
      // aborted op leaves no stale value visible on the outputs.
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_sign   <= 1'b0;
    end else if (w_load) begin
      r_result <= w_load_val.result;
      r_zero   <= (w_load_val.result == '0);
      r_sign   <= w_load_val.result[WIDTH-1];
      r_carry  <= w_load_val.carry;
      r_ovf    <= w_load_val.ovf;
    end
  end

  assign bus.In_Ready  = w_in_ready;
  assign bus.Out_Valid = w_out_valid;
  assign bus.Result    = r_result;
  assign bus.Zero      = r_zero;
  assign bus.Carry     = r_carry;
  assign bus.Overflow  = r_ovf;
  assign bus.Sign      = r_sign;

endmodule
